// File: rtl/seg_link_pkg.sv
// rtl/seg_link_pkg.sv - shared constants and FSM state type for the seven-segment serial link
package seg_link_pkg;

  localparam int FRAME_BITS   = 96;
  localparam int BRIGHT_BITS  = 8;
  localparam int RED_OFS      = 16;
  localparam int GRN_OFS      = 8;
  localparam int ANODE_OFS    = 0;
  localparam int DIGIT_STRIDE = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_STROBE,
    ST_END
  } state_e;

endpackage

// File: rtl/seg_frame_pack.sv
// rtl/seg_frame_pack.sv - packs per-digit red/green/anode enables into the 96-bit frame word
module seg_frame_pack
  import seg_link_pkg::*;
(
  input  logic [27:0]           red_i,
  input  logic [27:0]           grn_i,
  input  logic [23:0]           anode_i,
  output logic [FRAME_BITS-1:0] frame_o
);

  // Digit 1 occupies the lowest 24 bits; unused pad bits stay zero.
  always_comb begin
    frame_o = '0;
    for (int d = 0; d < 4; d++) begin
      frame_o[d*DIGIT_STRIDE + RED_OFS   +: 7] = red_i[d*7 +: 7];
      frame_o[d*DIGIT_STRIDE + GRN_OFS   +: 7] = grn_i[d*7 +: 7];
      frame_o[d*DIGIT_STRIDE + ANODE_OFS +: 6] = anode_i[d*6 +: 6];
    end
  end

endmodule

// File: rtl/seg_frame_tx.sv
// rtl/seg_frame_tx.sv - serializes a display frame or brightness byte, then strobes latch or pwm
module seg_frame_tx
  import seg_link_pkg::*;
#(
  parameter int DIV        = 4,
  parameter int STROBE_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [27:0] red_in,
  input  logic [27:0] grn_in,
  input  logic [23:0] anode_in,
  input  logic [7:0]  bright_in,
  input  logic        req_frame,
  input  logic        req_bright,
  output logic        busy,
  output logic        done,
  output logic        ser_clk,
  output logic        ser_data,
  output logic        latch,
  output logic        pwm
);

  localparam logic [7:0] DIV_LAST    = 8'(DIV - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_LEN);
  localparam logic [6:0] FRAME_TOP   = 7'(FRAME_BITS - 1);
  localparam logic [6:0] BRIGHT_TOP  = 7'(BRIGHT_BITS - 1);

  state_e                state_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] frame_word;
  logic [6:0]            bit_q;
  logic [7:0]            div_q;
  logic                  is_frame_q;
  logic                  pend_frame_q, pend_bright_q;
  logic                  pend_frame_d, pend_bright_d;
  logic                  busy_q, done_q, ser_clk_q, ser_data_q, latch_q, pwm_q;
  logic                  can_start, start_frame, start_bright;

  seg_frame_pack u_pack (
    .red_i   (red_in),
    .grn_i   (grn_in),
    .anode_i (anode_in),
    .frame_o (frame_word)
  );

  // END doubles as a start point so a pending job follows with a single idle cycle.
  assign can_start    = (state_q == ST_IDLE) || (state_q == ST_END);
  assign start_frame  = can_start && pend_frame_q;
  assign start_bright = can_start && !pend_frame_q && pend_bright_q;

  always_comb begin
    pend_frame_d  = (pend_frame_q && !start_frame) || req_frame;
    pend_bright_d = (pend_bright_q && !start_bright) || req_bright;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      shift_q       <= '0;
      bit_q         <= '0;
      div_q         <= '0;
      is_frame_q    <= 1'b0;
      pend_frame_q  <= 1'b0;
      pend_bright_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ser_clk_q     <= 1'b0;
      ser_data_q    <= 1'b0;
      latch_q       <= 1'b0;
      pwm_q         <= 1'b0;
    end else begin
      pend_frame_q  <= pend_frame_d;
      pend_bright_q <= pend_bright_d;
      done_q        <= 1'b0;
      case (state_q)
        ST_IDLE, ST_END: begin
          if (start_frame || start_bright) begin
            state_q    <= ST_LOW;
            busy_q     <= 1'b1;
            div_q      <= '0;
            ser_clk_q  <= 1'b0;
            is_frame_q <= start_frame;
            shift_q    <= start_frame ? frame_word
                                      : {bright_in, {(FRAME_BITS-BRIGHT_BITS){1'b0}}};
            ser_data_q <= start_frame ? frame_word[FRAME_BITS-1] : bright_in[7];
            bit_q      <= start_frame ? FRAME_TOP : BRIGHT_TOP;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_LOW: begin
          if (div_q == DIV_LAST) begin
            state_q   <= ST_HIGH;
            ser_clk_q <= 1'b1;
            div_q     <= '0;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        ST_HIGH: begin
          if (div_q == DIV_LAST) begin
            ser_clk_q <= 1'b0;
            div_q     <= '0;
            if (bit_q != '0) begin
              state_q    <= ST_LOW;
              bit_q      <= bit_q - 7'd1;
              shift_q    <= shift_q << 1;
              ser_data_q <= shift_q[FRAME_BITS-2];
            end else begin
              state_q    <= ST_STROBE;
              ser_data_q <= 1'b0;
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        ST_STROBE: begin
          // First STROBE cycle keeps the strobe low so it rises after the final ser_clk fall.
          if (div_q == STROBE_LAST) begin
            state_q <= ST_END;
            latch_q <= 1'b0;
            pwm_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            div_q   <= '0;
          end else begin
            latch_q <= is_frame_q;
            pwm_q   <= !is_frame_q;
            div_q   <= div_q + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ser_clk  = ser_clk_q;
  assign ser_data = ser_data_q;
  assign latch    = latch_q;
  assign pwm      = pwm_q;

endmodule

// File: tb/tb_seg_frame_tx.sv
// tb/tb_seg_frame_tx.sv - directed self-checking bench for seg_frame_tx (default and DIV=1 instances)
module tb_seg_frame_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [27:0] red_in = '0;
  logic [27:0] grn_in = '0;
  logic [23:0] anode_in = '0;
  logic [7:0]  bright_in = '0;
  logic [1:0]  req_frame = '0;
  logic [1:0]  req_bright = '0;
  logic [1:0]  busy_w, done_w, sclk_w, sdat_w, latch_w, pwm_w;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [95:0] F_ONE = 96'h000000_000000_000000_010001;
  localparam logic [95:0] F_ALL = {4{24'h7F7F3F}};

  logic [127:0] cap [2];
  int    rises [2], since_rise [2], rg_min [2], rg_max [2], viol [2];
  int    latch_n [2], latch_wid [2], pwm_n [2], pwm_wid [2], done_n [2];
  int    busy_cyc [2], run_cur [2], nruns [2], idle_cnt [2], gap [2];
  int    runs [2][4];
  string ev [2];
  logic [1:0] prev_sclk = '0, prev_sdat = '0, prev_latch = '0, prev_pwm = '0, prev_busy = '0;

  always #5 clk = ~clk;

  seg_frame_tx u_dut (
    .clk(clk), .rst(rst), .red_in(red_in), .grn_in(grn_in), .anode_in(anode_in),
    .bright_in(bright_in), .req_frame(req_frame[0]), .req_bright(req_bright[0]),
    .busy(busy_w[0]), .done(done_w[0]), .ser_clk(sclk_w[0]), .ser_data(sdat_w[0]),
    .latch(latch_w[0]), .pwm(pwm_w[0])
  );

  seg_frame_tx #(.DIV(1), .STROBE_LEN(1)) u_fast (
    .clk(clk), .rst(rst), .red_in(red_in), .grn_in(grn_in), .anode_in(anode_in),
    .bright_in(bright_in), .req_frame(req_frame[1]), .req_bright(req_bright[1]),
    .busy(busy_w[1]), .done(done_w[1]), .ser_clk(sclk_w[1]), .ser_data(sdat_w[1]),
    .latch(latch_w[1]), .pwm(pwm_w[1])
  );

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      since_rise[k]++;
      if (sclk_w[k] && !prev_sclk[k]) begin
        if (rises[k] > 0) begin
          if (since_rise[k] < rg_min[k]) rg_min[k] = since_rise[k];
          if (since_rise[k] > rg_max[k]) rg_max[k] = since_rise[k];
        end
        since_rise[k] = 0;
        rises[k]++;
        cap[k] = {cap[k][126:0], sdat_w[k]};
      end
      if (sclk_w[k] && (sdat_w[k] !== prev_sdat[k])) viol[k]++;
      if (latch_w[k]) begin
        if (!prev_latch[k]) begin latch_n[k]++; ev[k] = {ev[k], "L"}; latch_wid[k] = 0; end
        latch_wid[k]++;
      end
      if (pwm_w[k]) begin
        if (!prev_pwm[k]) begin pwm_n[k]++; ev[k] = {ev[k], "P"}; pwm_wid[k] = 0; end
        pwm_wid[k]++;
      end
      if (done_w[k]) begin done_n[k]++; ev[k] = {ev[k], "D"}; end
      if (busy_w[k]) begin
        busy_cyc[k]++;
        if (!prev_busy[k]) begin
          if (nruns[k] > 0) gap[k] = idle_cnt[k];
          run_cur[k] = 0;
        end
        run_cur[k]++;
      end else begin
        if (prev_busy[k]) begin
          if (nruns[k] < 4) runs[k][nruns[k]] = run_cur[k];
          nruns[k]++;
          idle_cnt[k] = 0;
        end
        idle_cnt[k]++;
      end
      prev_sclk[k]  = sclk_w[k];
      prev_sdat[k]  = sdat_w[k];
      prev_latch[k] = latch_w[k];
      prev_pwm[k]   = pwm_w[k];
      prev_busy[k]  = busy_w[k];
    end
  end

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      cap[k] = '0; rises[k] = 0; since_rise[k] = 0; rg_min[k] = 1000; rg_max[k] = 0;
      viol[k] = 0; latch_n[k] = 0; latch_wid[k] = 0; pwm_n[k] = 0; pwm_wid[k] = 0;
      done_n[k] = 0; busy_cyc[k] = 0; run_cur[k] = 0; nruns[k] = 0; idle_cnt[k] = 0;
      gap[k] = -1; ev[k] = "";
      for (int j = 0; j < 4; j++) runs[k][j] = 0;
    end
  endtask

  task automatic pulse_req(input int k, input bit f, input bit b);
    @(posedge clk); #1;
    req_frame[k] = f; req_bright[k] = b;
    @(posedge clk); #1;
    req_frame[k] = 1'b0; req_bright[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int n, input int limit);
    for (int c = 0; c < limit && done_n[k] < n; c++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({busy_w[k], done_w[k], sclk_w[k], sdat_w[k], latch_w[k], pwm_w[k]} !== 6'b0)
        $display("FAIL reset_outputs[%0d]: got %b expected 000000", k,
                 {busy_w[k], done_w[k], sclk_w[k], sdat_w[k], latch_w[k], pwm_w[k]});
      else n_pass++;
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_frame();
    red_in = 28'h0000001; grn_in = '0; anode_in = 24'h000001;
    clear_stats();
    pulse_req(0, 1'b1, 1'b0);
    wait_done(0, 1, 2000);
    n_checks++; if (done_n[0] !== 1) $display("FAIL frame_done: got %0d expected 1", done_n[0]); else n_pass++;
    n_checks++; if (cap[0][95:0] !== F_ONE) $display("FAIL frame_bits: got %h expected %h", cap[0][95:0], F_ONE); else n_pass++;
    n_checks++; if (rises[0] !== 96) $display("FAIL frame_rises: got %0d expected 96", rises[0]); else n_pass++;
    n_checks++; if (latch_n[0] !== 1 || latch_wid[0] !== 4) $display("FAIL frame_latch: got n=%0d w=%0d expected n=1 w=4", latch_n[0], latch_wid[0]); else n_pass++;
    n_checks++; if (nruns[0] !== 1 || runs[0][0] !== 773) $display("FAIL frame_busy: got runs=%0d len=%0d expected 1/773", nruns[0], runs[0][0]); else n_pass++;
    n_checks++; if (pwm_n[0] !== 0 || viol[0] !== 0) $display("FAIL frame_pwm_or_data: got pwm=%0d viol=%0d expected 0/0", pwm_n[0], viol[0]); else n_pass++;
  endtask

  task automatic test_bright();
    bright_in = 8'hA5;
    clear_stats();
    pulse_req(0, 1'b0, 1'b1);
    wait_done(0, 1, 500);
    n_checks++; if (done_n[0] !== 1) $display("FAIL bright_done: got %0d expected 1", done_n[0]); else n_pass++;
    n_checks++; if (cap[0][7:0] !== 8'hA5 || rises[0] !== 8) $display("FAIL bright_bits: got %h/%0d expected a5/8", cap[0][7:0], rises[0]); else n_pass++;
    n_checks++; if (pwm_n[0] !== 1 || pwm_wid[0] !== 4) $display("FAIL bright_pwm: got n=%0d w=%0d expected n=1 w=4", pwm_n[0], pwm_wid[0]); else n_pass++;
    n_checks++; if (latch_n[0] !== 0) $display("FAIL bright_latch: got %0d expected 0", latch_n[0]); else n_pass++;
    n_checks++; if (runs[0][0] !== 69) $display("FAIL bright_busy: got %0d expected 69", runs[0][0]); else n_pass++;
  endtask

  task automatic test_simultaneous();
    clear_stats();
    pulse_req(0, 1'b1, 1'b1);
    wait_done(0, 2, 3000);
    n_checks++; if (done_n[0] !== 2) $display("FAIL simul_done: got %0d expected 2", done_n[0]); else n_pass++;
    n_checks++; if (cap[0][103:0] !== {F_ONE, 8'hA5} || rises[0] !== 104) $display("FAIL simul_bits: got %h/%0d expected %h/104", cap[0][103:0], rises[0], {F_ONE, 8'hA5}); else n_pass++;
    n_checks++; if (ev[0] != "LDPD") $display("FAIL simul_order: got %s expected LDPD", ev[0]); else n_pass++;
    n_checks++; if (gap[0] !== 1) $display("FAIL simul_gap: got %0d expected 1", gap[0]); else n_pass++;
    n_checks++; if (runs[0][0] !== 773 || runs[0][1] !== 69) $display("FAIL simul_busy: got %0d/%0d expected 773/69", runs[0][0], runs[0][1]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic pre_busy;
    clear_stats();
    pulse_req(0, 1'b1, 1'b0);
    pulse_req(0, 1'b0, 1'b1);
    for (int c = 0; c < 1000 && rises[0] < 40; c++) @(negedge clk);
    n_checks++; if (rises[0] < 40) $display("FAIL rstmid_reach: got %0d expected >=40", rises[0]); else n_pass++;
    pre_busy = busy_w[0];
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({pre_busy, busy_w[0], done_w[0], sclk_w[0], sdat_w[0], latch_w[0], pwm_w[0]} !== 7'b1000000)
      $display("FAIL rstmid_outputs: got %b expected 1000000",
               {pre_busy, busy_w[0], done_w[0], sclk_w[0], sdat_w[0], latch_w[0], pwm_w[0]});
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    clear_stats();
    repeat (100) @(negedge clk);
    n_checks++; if (busy_cyc[0] !== 0 || done_n[0] !== 0) $display("FAIL rstmid_idle: got busy=%0d done=%0d expected 0/0", busy_cyc[0], done_n[0]); else n_pass++;
    n_checks++; if (latch_n[0] !== 0 || pwm_n[0] !== 0) $display("FAIL rstmid_strobe: got latch=%0d pwm=%0d expected 0/0", latch_n[0], pwm_n[0]); else n_pass++;
  endtask

  task automatic test_merge();
    red_in = 28'h0000001;
    clear_stats();
    pulse_req(0, 1'b1, 1'b0);
    repeat (50) @(posedge clk);
    red_in = 28'hFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      pulse_req(0, 1'b0, 1'b1);
      repeat (20) @(posedge clk);
    end
    wait_done(0, 2, 3000);
    repeat (200) @(negedge clk);
    n_checks++; if (done_n[0] !== 2 || nruns[0] !== 2) $display("FAIL merge_count: got done=%0d runs=%0d expected 2/2", done_n[0], nruns[0]); else n_pass++;
    n_checks++; if (pwm_n[0] !== 1) $display("FAIL merge_pwm: got %0d expected 1", pwm_n[0]); else n_pass++;
    n_checks++; if (cap[0][103:0] !== {F_ONE, 8'hA5}) $display("FAIL merge_snapshot: got %h expected %h", cap[0][103:0], {F_ONE, 8'hA5}); else n_pass++;
  endtask

  task automatic test_div1();
    red_in = 28'hFFFFFFF; grn_in = 28'hFFFFFFF; anode_in = 24'hFFFFFF;
    clear_stats();
    pulse_req(1, 1'b1, 1'b0);
    wait_done(1, 1, 1000);
    n_checks++; if (done_n[1] !== 1) $display("FAIL div1_done: got %0d expected 1", done_n[1]); else n_pass++;
    n_checks++; if (cap[1][95:0] !== F_ALL || rises[1] !== 96) $display("FAIL div1_bits: got %h/%0d expected %h/96", cap[1][95:0], rises[1], F_ALL); else n_pass++;
    n_checks++; if (rg_min[1] !== 2 || rg_max[1] !== 2) $display("FAIL div1_period: got %0d..%0d expected 2..2", rg_min[1], rg_max[1]); else n_pass++;
    n_checks++; if (latch_n[1] !== 1 || latch_wid[1] !== 1) $display("FAIL div1_latch: got n=%0d w=%0d expected 1/1", latch_n[1], latch_wid[1]); else n_pass++;
    n_checks++; if (runs[1][0] !== 194) $display("FAIL div1_busy: got %0d expected 194", runs[1][0]); else n_pass++;
    n_checks++; if (busy_cyc[0] !== 0) $display("FAIL div1_other_idle: got %0d expected 0", busy_cyc[0]); else n_pass++;
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_frame();
    test_bright();
    test_simultaneous();
    test_reset_mid();
    test_merge();
    test_div1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
